sine_burst_ctrl: RTL and testbench

Burst sequencer for the sine-wave datapath inside the reconfigurable module. It accepts burst commands over a valid/ready handshake and steps a phase accumulator to address an external sine lookup table. It realigns the table's output with a valid/last stream for the downstream capture/ILA probes. It also emits a one-cycle trigger at burst start so debug capture can be armed on it.

---
 rtl/sine_burst_pkg.sv | 9 +
 rtl/sine_burst_align.sv | 36 +++
 rtl/sine_burst_ctrl.sv | 129 ++++++++++++
 tb/tb_sine_burst_ctrl.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sine_burst_pkg.sv
// sine_burst_pkg: shared state encoding and default widths for the sine burst sequencer
package sine_burst_pkg;
    localparam int DEF_PHASE_W = 24;
    localparam int DEF_ADDR_W  = 10;
    localparam int DEF_DATA_W  = 16;
    localparam int DEF_LEN_W   = 16;
    localparam int DEF_LUT_LAT = 2;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;
endpackage

// File: rtl/sine_burst_align.sv
// sine_burst_align: LAT-deep valid/last delay line matching the LUT read latency.
// Ports: clk, rst_n (async, active-low); flush_i clears every stage synchronously;
// valid_i/last_i enter per issue; valid_o/last_o leave LAT cycles later;
// empty_o is high when nothing is queued behind the output stage, so the pipe
// is empty after the next edge.
module sine_burst_align #(
    parameter int LAT = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    input  logic valid_i,
    input  logic last_i,
    output logic valid_o,
    output logic last_o,
    output logic empty_o
);
    logic [LAT-1:0] v_q, v_d, l_q, l_d, rest;
    always_comb begin
        v_d  = flush_i ? '0 : (v_q << 1) | LAT'(valid_i);
        l_d  = flush_i ? '0 : (l_q << 1) | LAT'(valid_i & last_i);
        rest = v_q << 1;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
            l_q <= '0;
        end else begin
            v_q <= v_d;
            l_q <= l_d;
        end
    end
    assign valid_o = v_q[LAT-1];
    assign last_o  = l_q[LAT-1];
    assign empty_o = rest == '0;
endmodule

// File: rtl/sine_burst_ctrl.sv
// sine_burst_ctrl: burst sequencer stepping a phase accumulator into an external sine LUT.
// Ports: clk, rst_n (async, active-low); cmd_valid/cmd_ready handshake with
// cmd_step/cmd_len/cmd_shift; abort ends a running burst; lut_addr/lut_data to
// the LUT; smp_valid/smp_data/smp_last aligned sample stream; busy, done, trig status.
// Build option SINE_BURST_CTRL_ATTEN_EN: adds a registered arithmetic-shift
// attenuation stage on the sample stream (one extra cycle of latency).
module sine_burst_ctrl
    import sine_burst_pkg::*;
#(
    parameter int PHASE_W = DEF_PHASE_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int LUT_LAT = DEF_LUT_LAT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [PHASE_W-1:0]       cmd_step,
    input  logic [LEN_W-1:0]         cmd_len,
    input  logic [3:0]               cmd_shift,
    input  logic                     abort,
    output logic [ADDR_W-1:0]        lut_addr,
    input  logic signed [DATA_W-1:0] lut_data,
    output logic                     smp_valid,
    output logic signed [DATA_W-1:0] smp_data,
    output logic                     smp_last,
    output logic                     busy,
    output logic                     done,
    output logic                     trig
);
    state_e             state_q, state_d;
    logic [PHASE_W-1:0] phase_q, phase_d, step_q;
    logic [LEN_W-1:0]   len_q, cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q;
    logic               trig_q, accept, issue, last_issue, flush;
    logic               pipe_valid, pipe_last, pipe_empty, drain_ok;
    assign accept     = state_q == IDLE && cmd_valid;
    assign issue      = state_q == RUN;
    assign last_issue = issue && cnt_q == len_q - LEN_W'(1);
    assign flush      = abort && (state_q == RUN || state_q == DRAIN);
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: if (cmd_valid) begin
                state_d = cmd_len == '0 ? DONE : RUN;
                phase_d = '0;
                cnt_d   = '0;
            end
            RUN: begin
                phase_d = phase_q + step_q;
                cnt_d   = cnt_q + LEN_W'(1);
                state_d = abort ? DONE : last_issue ? DRAIN : RUN;
            end
            DRAIN:   state_d = abort || drain_ok ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            step_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            trig_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            trig_q  <= accept && cmd_len != '0;
            if (accept) begin
                step_q <= cmd_step;
                len_q  <= cmd_len;
            end
            // Address only advances while issuing, so it holds outside RUN.
            if (state_d == RUN) addr_q <= phase_d[PHASE_W-1 -: ADDR_W];
        end
    end
    sine_burst_align #(.LAT(LUT_LAT)) u_align (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush_i (flush),
        .valid_i (issue),
        .last_i  (last_issue),
        .valid_o (pipe_valid),
        .last_o  (pipe_last),
        .empty_o (pipe_empty)
    );
`ifdef SINE_BURST_CTRL_ATTEN_EN
    logic [3:0]               shift_q;
    logic                     smp_valid_q, smp_last_q;
    logic signed [DATA_W-1:0] smp_data_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q     <= '0;
            smp_valid_q <= 1'b0;
            smp_last_q  <= 1'b0;
            smp_data_q  <= '0;
        end else begin
            if (accept) shift_q <= cmd_shift;
            smp_valid_q <= pipe_valid && !flush;
            smp_last_q  <= pipe_last && !flush;
            smp_data_q  <= lut_data >>> shift_q;
        end
    end
    assign smp_valid = smp_valid_q;
    assign smp_last  = smp_last_q;
    assign smp_data  = smp_data_q;
    // The output register holds the final sample one cycle longer.
    assign drain_ok  = pipe_empty && !pipe_valid;
`else
    logic unused_shift;
    assign unused_shift = ^cmd_shift;
    assign smp_valid    = pipe_valid;
    assign smp_last     = pipe_last;
    assign smp_data     = lut_data;
    assign drain_ok     = pipe_empty;
`endif
    assign lut_addr  = addr_q;
    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign done      = state_q == DONE;
    assign trig      = trig_q;
endmodule

// File: tb/tb_sine_burst_ctrl.sv
// tb_sine_burst_ctrl: directed self-checking bench for sine_burst_ctrl with a ramp LUT model
module tb_sine_burst_ctrl;
    import sine_burst_pkg::*;
    localparam int LAT = DEF_LUT_LAT;
`ifdef SINE_BURST_CTRL_ATTEN_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif
    logic clk, rst_n, cmd_valid, cmd_ready, abort;
    logic [23:0] cmd_step;
    logic [15:0] cmd_len;
    logic [3:0] cmd_shift;
    logic [9:0] lut_addr, last_a;
    logic signed [15:0] lut_data, smp_data;
    logic smp_valid, smp_last, busy, done, trig;
    logic [9:0] lp [LAT];
    int n_chk = 0, n_pass = 0;

    sine_burst_ctrl dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_step(cmd_step), .cmd_len(cmd_len), .cmd_shift(cmd_shift), .abort(abort),
        .lut_addr(lut_addr), .lut_data(lut_data), .smp_valid(smp_valid),
        .smp_data(smp_data), .smp_last(smp_last), .busy(busy), .done(done), .trig(trig)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic signed [15:0] lutf(input logic [9:0] a);
        return {{6{a[9]}}, a};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) lp[i] <= '0;
        end else begin
            lp[0] <= lut_addr;
            for (int i = 1; i < LAT; i++) lp[i] <= lp[i-1];
        end
    end
    assign lut_data = lutf(lp[LAT-1]);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic go(input int id, input logic [23:0] st, input logic [15:0] ln,
                      input logic [3:0] sh, input int ab, input bit ab_acc, input bit hold);
        int lat, dc, ncyc, idx, k;
        bit ev, el;
        logic [23:0] p;
        logic [9:0] ea;
        logic signed [15:0] ed;
        lat  = LAT + XL;
        dc   = ab > 0 ? ab + 1 : (ln == 0 ? 1 : 1 + int'(ln) + lat);
        ncyc = dc + 1;
        ea   = last_a;
        cmd_valid = 1'b1; cmd_step = st; cmd_len = ln; cmd_shift = sh; abort = ab_acc;
        @(posedge clk);
        @(negedge clk);
        abort = 1'b0;
        if (hold) begin
            cmd_step = st + 24'd7; cmd_len = ln + 16'd5; cmd_shift = sh ^ 4'hf;
        end else cmd_valid = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            k  = c - 1 - lat;
            ev = ln != 0 && k >= 0 && k < int'(ln) && (ab == 0 || c <= ab);
            el = ev && k == int'(ln) - 1;
            if (ln != 0) begin
                idx = (ab > 0 && c > ab) ? ab - 1 : (c > int'(ln) ? int'(ln) - 1 : c - 1);
                p   = st * 24'(idx);
                ea  = p[23:14];
            end
            chk($sformatf("b%0d c%0d valid", id, c), 32'(smp_valid), 32'(ev));
            chk($sformatf("b%0d c%0d last", id, c), 32'(smp_last), 32'(el));
            chk($sformatf("b%0d c%0d done", id, c), 32'(done), 32'(c == dc));
            chk($sformatf("b%0d c%0d trig", id, c), 32'(trig), 32'(ln != 0 && c == 1));
            chk($sformatf("b%0d c%0d busy", id, c), 32'(busy), 32'(c <= dc));
            chk($sformatf("b%0d c%0d ready", id, c), 32'(cmd_ready), 32'(c > dc));
            chk($sformatf("b%0d c%0d addr", id, c), 32'(lut_addr), 32'(ea));
            if (ev) begin
                p  = st * 24'(k);
                ed = lutf(p[23:14]);
                if (XL == 1) ed = ed >>> sh;
                chk($sformatf("b%0d c%0d data", id, c), 32'(smp_data), 32'(ed));
            end
            abort = c == ab;
            if (c < ncyc) @(negedge clk);
        end
        abort  = 1'b0;
        last_a = ea;
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_step = '0; cmd_len = '0; cmd_shift = '0;
        abort = 1'b0; last_a = '0;
        repeat (2) @(negedge clk);
        chk("rst ready", 32'(cmd_ready), 32'd1);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst trig", 32'(trig), 32'd0);
        chk("rst valid", 32'(smp_valid), 32'd0);
        chk("rst last", 32'(smp_last), 32'd0);
        chk("rst data", 32'(smp_data), 32'd0);
        chk("rst addr", 32'(lut_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        go(1, 24'h004000, 16'd4, 4'd0, 0, 1'b0, 1'b0);
        go(2, 24'h004000, 16'd0, 4'd0, 0, 1'b0, 1'b0);
        go(3, 24'h800001, 16'd3, 4'd0, 0, 1'b0, 1'b0);
        go(4, 24'(1008 << 14), 16'd2, 4'd3, 0, 1'b0, 1'b0);
        go(5, 24'(100 << 14), 16'd2, 4'd15, 0, 1'b0, 1'b0);
        go(6, 24'h004000, 16'd8, 4'd0, 3, 1'b0, 1'b0);
        go(7, 24'h008000, 16'd3, 4'd0, 0, 1'b1, 1'b0);
        go(8, 24'h00c000, 16'd2, 4'd1, 0, 1'b0, 1'b1);
        go(9, 24'h00c007, 16'd7, 4'he, 0, 1'b0, 1'b0);
        cmd_valid = 1'b1; cmd_step = 24'h004000; cmd_len = 16'd8; cmd_shift = '0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid valid", 32'(smp_valid), 32'd1);
        chk("mid busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst valid", 32'(smp_valid), 32'd0);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst ready", 32'(cmd_ready), 32'd1);
        chk("arst addr", 32'(lut_addr), 32'd0);
        chk("arst data", 32'(smp_data), 32'd0);
        chk("arst last", 32'(smp_last), 32'd0);
        chk("arst trig", 32'(trig), 32'd0);
        chk("arst done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post ready", 32'(cmd_ready), 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
